cic_comb_scheduler: RTL and testbench

//  Time-multiplexed comb section for the multichannel CIC decimator. One W-bit subtractor
//  is shared across CH mic channels and STAGES cascaded comb stages.
//  Per-channel, per-stage delay registers are held in an internal array.

---
 rtl/cic_comb_scheduler.sv | 120 ++++++++++++
 tb/tb_cic_comb_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_comb_scheduler.sv
// Time-multiplexed CIC comb section: one shared subtractor serves CH channels x STAGES stages.
// Latency: input accept at cycle T -> out_valid at T+STAGES+1; at most one sample per STAGES+2 cycles.
// Backpressure: in_ready low outside IDLE (upstream holds in_valid); result held in OUT until out_ready.
module cic_comb_scheduler #(
   parameter int W      = 19,
   parameter int CH     = 8,
   parameter int STAGES = 3,
   localparam int CW    = $clog2(CH)
) (
   input  logic          lr_clock,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [CW-1:0] in_ch,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] out_ch,
   output logic          drop
);

   localparam int N  = CH * STAGES;
   localparam int NW = $clog2(N);
   localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

   typedef enum logic [1:0] {CLR, IDLE, COMB, OUT} state_t;

   state_t        state;
   state_t        state_nxt;

   // Delay line storage, flattened as entry ch*STAGES + s.
   logic [W-1:0]  d [N];
   logic [NW-1:0] clr_cnt;
   logic [W-1:0]  x;
   logic [CW-1:0] ch;
   logic [SW-1:0] s;
   logic          drop_q;

   logic          in_fire;
   logic          ch_ok;
   logic          last_clr;
   logic          last_stage;
   logic [NW-1:0] idx;

   assign in_fire    = in_valid & in_ready;
   // Out-of-range channel indices only exist when CH is not a power of two.
   assign ch_ok      = int'(in_ch) < CH;
   assign last_clr   = (clr_cnt == NW'(N - 1));
   assign last_stage = (s == SW'(STAGES - 1));
   assign idx        = NW'(int'(ch) * STAGES + int'(s));

   // State register; reset always restarts the delay-line clear.
   always_ff @(posedge lr_clock) begin
      if (rst) state <= CLR;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         CLR:     if (last_clr) state_nxt = IDLE;
         IDLE:    if (in_fire && ch_ok) state_nxt = COMB;
         COMB:    if (last_stage) state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = CLR;
      endcase
   end

   // Outputs decoded from state; the result registers drive the data outputs directly.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == OUT);
      out_data  = x;
      out_ch    = ch;
      drop      = drop_q;
   end

   // Control and working registers: clear counter, sample accumulator, channel, stage, drop pulse.
   always_ff @(posedge lr_clock) begin
      if (rst) begin
         clr_cnt <= '0;
         x       <= '0;
         ch      <= '0;
         s       <= '0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         case (state)
            CLR: clr_cnt <= clr_cnt + 1'b1;
            IDLE: begin
               if (in_fire) begin
                  if (ch_ok) begin
                     x  <= in_data;
                     ch <= in_ch;
                     s  <= '0;
                  end else begin
                     drop_q <= 1'b1;
                  end
               end
            end
            COMB: begin
               x <= x - d[idx];
               s <= s + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Delay-line writes: zero fill during CLR, pre-subtraction value during COMB.
   always_ff @(posedge lr_clock) begin
      if (!rst) begin
         if (state == CLR)       d[clr_cnt] <= '0;
         else if (state == COMB) d[idx]     <= x;
      end
   end

endmodule

// File: tb/tb_cic_comb_scheduler.sv
module tb_cic_comb_scheduler;

   logic        clk;
   logic        rst_a, rst_b;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_drop;
   logic [18:0] a_in_data, a_out_data;
   logic [2:0]  a_in_ch, a_out_ch;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_drop;
   logic [18:0] b_in_data, b_out_data;
   logic [2:0]  b_in_ch, b_out_ch;

   int tests = 0;
   int fails = 0;

   // Instance A: default CH=8, STAGES=3.
   cic_comb_scheduler #(.W(19), .CH(8), .STAGES(3)) dut_a (
      .lr_clock(clk), .rst(rst_a),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ch(a_in_ch),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ch(a_out_ch),
      .drop(a_drop)
   );

   // Instance B: STAGES=1 for wrap, CH=6 so an out-of-range channel index is encodable.
   cic_comb_scheduler #(.W(19), .CH(6), .STAGES(1)) dut_b (
      .lr_clock(clk), .rst(rst_b),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ch(b_in_ch),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ch(b_out_ch),
      .drop(b_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic send(input bit b, input int c, input int v);
      int n;
      n = 0;
      while (!(b ? b_in_ready : a_in_ready) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
      end
      if (b) begin b_in_valid = 1'b1; b_in_data = 19'(v); b_in_ch = 3'(c); end
      else   begin a_in_valid = 1'b1; a_in_data = 19'(v); a_in_ch = 3'(c); end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
   endtask

   task automatic get(input bit b, output logic [18:0] dat, output logic [2:0] c,
                      output int lat, output bit ok);
      lat = 0; ok = 1'b0; dat = '0; c = '0;
      while (lat < 50) begin
         if (b ? b_out_valid : a_out_valid) begin
            ok  = 1'b1;
            dat = b ? b_out_data : a_out_data;
            c   = b ? b_out_ch : a_out_ch;
            break;
         end
         @(posedge clk); #1; lat++;
      end
      if (ok) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      int na, nb, k;
      bit bad;
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_drop !== 1'b0 ||
          a_out_data !== 19'd0 || a_out_ch !== 3'd0) begin
         fails++;
         $display("FAIL reset_outputs: rdy=%b vld=%b drop=%b data=%0d ch=%0d, required all 0",
                  a_in_ready, a_out_valid, a_drop, a_out_data, a_out_ch);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      na = 0; nb = 0; k = 0; bad = 1'b0;
      while ((!a_in_ready || !b_in_ready) && k < 100) begin
         if (!a_in_ready) na++;
         if (!b_in_ready) nb++;
         if (a_out_valid || a_drop || b_out_valid || b_drop) bad = 1'b1;
         @(posedge clk); #1; k++;
      end
      tests++;
      if (na != 24) begin fails++; $display("FAIL reset_clr_len_a: %0d cycles, required 24", na); end
      tests++;
      if (nb != 6) begin fails++; $display("FAIL reset_clr_len_b: %0d cycles, required 6", nb); end
      tests++;
      if (bad) begin fails++; $display("FAIL reset_quiet: out_valid/drop asserted during clear, required 0"); end
      tests++;
      if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: in_ready=%b, required 1", a_in_ready); end
   endtask

   task automatic run_impulse(input int cnt, input string tag);
      int exp_v [5];
      logic [18:0] dat, e;
      logic [2:0] c;
      int lat;
      bit ok;
      exp_v = '{1, -3, 3, -1, 0};
      for (int i = 0; i < cnt; i++) begin
         send(1'b0, 0, (i == 0) ? 1 : 0);
         get(1'b0, dat, c, lat, ok);
         e = 19'(exp_v[i]);
         tests++;
         if (!ok || dat !== e) begin
            fails++;
            $display("FAIL %s_data[%0d]: got %0d (valid=%b), required %0d", tag, i, $signed(dat), ok, $signed(e));
         end
         tests++;
         if (c !== 3'd0) begin fails++; $display("FAIL %s_ch[%0d]: got %0d, required 0", tag, i, c); end
         if (i == 0) begin
            tests++;
            if (lat != 3) begin fails++; $display("FAIL %s_latency: %0d cycles, required 3", tag, lat); end
         end
      end
   endtask

   task automatic test_impulse();
      run_impulse(5, "impulse");
   endtask

   task automatic test_interleave();
      int e2 [3];
      int e5 [3];
      logic [18:0] dat;
      logic [2:0] c;
      int lat;
      bit ok;
      e2 = '{5, -10, 5};
      e5 = '{7, -14, 7};
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 2, 5);
         get(1'b0, dat, c, lat, ok);
         tests++;
         if (!ok || dat !== 19'(e2[i]) || c !== 3'd2) begin
            fails++;
            $display("FAIL interleave_ch2[%0d]: got %0d ch %0d, required %0d ch 2", i, $signed(dat), c, e2[i]);
         end
         send(1'b0, 5, 7);
         get(1'b0, dat, c, lat, ok);
         tests++;
         if (!ok || dat !== 19'(e5[i]) || c !== 3'd5) begin
            fails++;
            $display("FAIL interleave_ch5[%0d]: got %0d ch %0d, required %0d ch 5", i, $signed(dat), c, e5[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [18:0] dat;
      logic [2:0] c;
      int lat;
      bit ok;
      send(1'b1, 1, -262144);
      get(1'b1, dat, c, lat, ok);
      tests++;
      if (!ok || dat !== 19'h40000 || lat != 1) begin
         fails++;
         $display("FAIL wrap_first: got %0d lat %0d, required -262144 lat 1", $signed(dat), lat);
      end
      send(1'b1, 1, 262143);
      get(1'b1, dat, c, lat, ok);
      tests++;
      if (!ok || dat !== 19'h7FFFF || c !== 3'd1) begin
         fails++;
         $display("FAIL wrap_second: got %0d ch %0d, required -1 ch 1", $signed(dat), c);
      end
   endtask

   task automatic test_backpressure();
      int n;
      bit unstable, rdy_bad;
      a_out_ready = 1'b0;
      send(1'b0, 3, 9);
      n = 0;
      while (!a_out_valid && n < 50) begin @(posedge clk); #1; n++; end
      unstable = 1'b0; rdy_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (a_out_valid !== 1'b1 || a_out_data !== 19'd9 || a_out_ch !== 3'd3) unstable = 1'b1;
         if (a_in_ready !== 1'b0) rdy_bad = 1'b1;
         @(posedge clk); #1;
      end
      tests++;
      if (unstable) begin
         fails++;
         $display("FAIL bp_stable: vld=%b data=%0d ch=%0d, required 1/9/3 for 10 cycles", a_out_valid, a_out_data, a_out_ch);
      end
      tests++;
      if (rdy_bad) begin fails++; $display("FAIL bp_in_ready: in_ready rose while held in OUT, required 0"); end
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_accept: vld=%b in_ready=%b one cycle after out_ready rose, required 0/1", a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_drop();
      bit bad;
      logic [18:0] dat;
      logic [2:0] c;
      int lat;
      bit ok;
      send(1'b1, 6, 123);
      tests++;
      if (b_drop !== 1'b1 || b_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL drop_pulse: drop=%b out_valid=%b, required 1/0", b_drop, b_out_valid);
      end
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (b_drop !== 1'b0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) bad = 1'b1;
      end
      tests++;
      if (bad) begin fails++; $display("FAIL drop_after: extra drop/output or not ready, required drop=0 vld=0 rdy=1"); end
      // ch1 history (262143) must survive the dropped sample: 5 - 262143 = -262138.
      send(1'b1, 1, 5);
      get(1'b1, dat, c, lat, ok);
      tests++;
      if (!ok || dat !== 19'(-262138)) begin
         fails++;
         $display("FAIL drop_no_side_effect: got %0d, required -262138", $signed(dat));
      end
   endtask

   task automatic test_reset_mid_comb();
      int n, k;
      bit bad;
      send(1'b0, 4, 50);
      rst_a = 1'b1;
      @(posedge clk); #1;
      rst_a = 1'b0;
      n = 0; k = 0; bad = 1'b0;
      while (!a_in_ready && k < 100) begin
         n++;
         if (a_out_valid) bad = 1'b1;
         @(posedge clk); #1; k++;
      end
      tests++;
      if (n != 24) begin fails++; $display("FAIL midrst_clr_len: %0d cycles, required 24", n); end
      tests++;
      if (bad || a_out_valid !== 1'b0) begin fails++; $display("FAIL midrst_no_output: out_valid rose, required 0"); end
      run_impulse(4, "midrst_impulse");
   endtask

   initial begin
      a_in_valid = 1'b0; a_in_data = '0; a_in_ch = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_ch = '0; b_out_ready = 1'b1;
      rst_a = 1'b1; rst_b = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_impulse();
      test_interleave();
      test_wrap();
      test_backpressure();
      test_drop();
      test_reset_mid_comb();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
